// File: rtl/prng_dice_roller.sv
// prng_dice_roller: push-button dice roller driven by an external random byte stream.
// The raw button is synchronized, debounced, then a rejection sampler draws from
// rnd_in[3:0] until it gets a value below the latched die size. After MAX_TRIES
// consecutive rejects it falls back to a result of 1.
// Optional feature: define PRNG_DICE_ROLL_COUNT_EN to enable the 8-bit roll counter;
// without it roll_count is tied to zero.
//
// valid/ready note: there is no ready input. valid is a one-cycle pulse, and result
// and fallback are stable from that cycle until the next pulse.
module prng_dice_roller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int MAX_TRIES       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rnd_in,
    input  logic       roll_in,
    input  logic [3:0] sides,
    output logic [3:0] result,
    output logic       valid,
    output logic       busy,
    output logic       fallback,
    output logic [7:0] roll_count
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_SAMPLE   = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    localparam logic [3:0] DEB_LIMIT = 4'(DEBOUNCE_CYCLES);
    localparam logic [3:0] TRY_LIMIT = 4'(MAX_TRIES);

    state_t     state;
    state_t     state_nxt;
    logic       roll_meta;
    logic       roll_s;
    logic [3:0] deb_cnt;
    logic [3:0] deb_cnt_nxt;
    logic [3:0] try_cnt;
    logic [3:0] try_cnt_nxt;
    logic [3:0] sides_q;
    logic [3:0] sides_q_nxt;
    logic       accept;
    logic [3:0] acc_result;
    logic       acc_fallback;
    logic [3:0] sample_v;

    // Only the low nibble of the random byte is used by the sampler.
    logic unused_rnd;
    assign unused_rnd = ^rnd_in[7:4];
    assign sample_v   = rnd_in[3:0];

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            roll_meta <= 1'b0;
            roll_s    <= 1'b0;
        end else begin
            roll_meta <= roll_in;
            roll_s    <= roll_meta;
        end
    end

    // State, counters and the latched die size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            deb_cnt <= 4'd0;
            try_cnt <= 4'd0;
            sides_q <= 4'd0;
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_cnt_nxt;
            try_cnt <= try_cnt_nxt;
            sides_q <= sides_q_nxt;
        end
    end

    // Next-state logic: debounce counts synchronized-high cycles including the one
    // seen in IDLE, so DEBOUNCE_CYCLES highs in a row lead into SAMPLE.
    always_comb begin
        state_nxt    = state;
        deb_cnt_nxt  = deb_cnt;
        try_cnt_nxt  = try_cnt;
        sides_q_nxt  = sides_q;
        accept       = 1'b0;
        acc_result   = result;
        acc_fallback = fallback;
        case (state)
            ST_IDLE: begin
                if (roll_s) begin
                    if (DEB_LIMIT <= 4'd1) begin
                        state_nxt   = ST_SAMPLE;
                        deb_cnt_nxt = 4'd0;
                        sides_q_nxt = sides;
                        try_cnt_nxt = 4'd0;
                    end else begin
                        state_nxt   = ST_DEBOUNCE;
                        deb_cnt_nxt = 4'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (!roll_s) begin
                    state_nxt   = ST_IDLE;
                    deb_cnt_nxt = 4'd0;
                end else if ((deb_cnt + 4'd1) >= DEB_LIMIT) begin
                    state_nxt   = ST_SAMPLE;
                    deb_cnt_nxt = 4'd0;
                    sides_q_nxt = sides;
                    try_cnt_nxt = 4'd0;
                end else begin
                    deb_cnt_nxt = deb_cnt + 4'd1;
                end
            end
            ST_SAMPLE: begin
                if (sides_q < 4'd2) begin
                    accept       = 1'b1;
                    acc_result   = 4'd1;
                    acc_fallback = 1'b0;
                end else if (sample_v < sides_q) begin
                    accept       = 1'b1;
                    acc_result   = sample_v + 4'd1;
                    acc_fallback = 1'b0;
                end else if ((try_cnt + 4'd1) >= TRY_LIMIT) begin
                    accept       = 1'b1;
                    acc_result   = 4'd1;
                    acc_fallback = 1'b1;
                end else begin
                    try_cnt_nxt = try_cnt + 4'd1;
                end
                if (accept) begin
                    state_nxt   = ST_HOLD;
                    try_cnt_nxt = 4'd0;
                end
            end
            ST_HOLD: begin
                if (!roll_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output registers: result/fallback only change on an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result   <= 4'd0;
            fallback <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= accept;
            if (accept) begin
                result   <= acc_result;
                fallback <= acc_fallback;
            end
        end
    end

    assign busy = (state == ST_DEBOUNCE) || (state == ST_SAMPLE);

`ifdef PRNG_DICE_ROLL_COUNT_EN
    logic [7:0] count_q;

    // Completed-roll counter, advanced together with the valid pulse; wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else if (accept) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign roll_count = count_q;
`else
    assign roll_count = 8'd0;
`endif

endmodule

// File: tb/tb_prng_dice_roller.sv
// Self-checking bench for prng_dice_roller with a cycle-indexed reference model.
module tb_prng_dice_roller;

    localparam int DEB  = 4;
    localparam int MAXT = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rnd_in;
    logic       roll_in;
    logic [3:0] sides;
    logic [3:0] result;
    logic       valid;
    logic       busy;
    logic       fallback;
    logic [7:0] roll_count;

    always #5 clk = ~clk;

    prng_dice_roller #(
        .DEBOUNCE_CYCLES(DEB),
        .MAX_TRIES      (MAXT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rnd_in    (rnd_in),
        .roll_in   (roll_in),
        .sides     (sides),
        .result    (result),
        .valid     (valid),
        .busy      (busy),
        .fallback  (fallback),
        .roll_count(roll_count)
    );

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    logic [7:0] rnd_hist[int];
    logic       roll_level = 1'b0;
    logic [3:0] sides_lvl = 4'd0;
    logic [7:0] script[$];
    int         script_base = -1000;
    int         valid_count = 0;
    int         last_valid_cyc = -1;
    logic [4:0] obs_q[$];
    logic [4:0] exp_q[$];
    int         exp_rolls = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_count();
`ifdef PRNG_DICE_ROLL_COUNT_EN
        return 32'(exp_rolls % 256);
`else
        return 32'd0;
`endif
    endfunction

    // One clock: drive this cycle's inputs after the edge, observe at the falling edge.
    task automatic step();
        int k;
        @(posedge clk);
        #1;
        cyc++;
        roll_in = roll_level;
        sides   = sides_lvl;
        k = cyc - script_base;
        if (k >= 0 && k < script.size()) rnd_in = script[k];
        else rnd_in = 8'($urandom);
        rnd_hist[cyc] = rnd_in;
        @(negedge clk);
        if (valid === 1'b1) begin
            valid_count++;
            last_valid_cyc = cyc;
            obs_q.push_back({fallback, result});
        end
    endtask

    // Reference: press visible from cycle p gives first draw at p+2+DEB; draws stop at
    // the first nibble below s, or after MAXT draws with fallback. valid follows a cycle later.
    task automatic model(input int first, input logic [3:0] s,
                         output logic [3:0] er, output logic ef, output int vcyc);
        bit         done;
        logic [3:0] v;
        er = 4'd1;
        ef = 1'b0;
        vcyc = first + 1;
        done = 1'b0;
        if (s >= 4'd2) begin
            for (int t = 0; t < MAXT; t++) begin
                if (!done) begin
                    v = rnd_hist[first + t][3:0];
                    if (v < s) begin
                        er = v + 4'd1;
                        vcyc = first + t + 1;
                        done = 1'b1;
                    end else if (t == MAXT - 1) begin
                        er = 4'd1;
                        ef = 1'b1;
                        vcyc = first + t + 1;
                        done = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic do_roll(input string tag, input logic [3:0] s, input int hold,
                           input bit scramble, input bit use_script);
        int         p, first, vc0, vcyc;
        logic [3:0] er;
        logic       ef;
        logic [4:0] o, e;
        sides_lvl = s;
        p = cyc + 1;
        first = p + 2 + DEB;
        if (use_script) script_base = first;
        vc0 = valid_count;
        obs_q.delete();
        roll_level = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (scramble && (cyc + 1) >= first) sides_lvl = 4'($urandom_range(0, 15));
            step();
            if (cyc == first) check({tag, "_busy_sample"}, 32'(busy), 32'd1);
        end
        roll_level = 1'b0;
        repeat (12) step();
        script_base = -1000;
        model(first, s, er, ef, vcyc);
        exp_q.push_back({ef, er});
        exp_rolls++;
        check({tag, "_npulse"}, 32'(valid_count - vc0), 32'd1);
        check({tag, "_vcyc"}, 32'(last_valid_cyc), 32'(vcyc));
        e = exp_q.pop_front();
        if (obs_q.size() > 0) o = obs_q.pop_front();
        else o = 5'bx;
        check({tag, "_out"}, 32'(o), 32'(e));
        check({tag, "_held"}, 32'({fallback, result}), 32'(e));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_count"}, 32'(roll_count), exp_count());
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_rolls = 0;
    endtask

    initial begin
        int         vc0, p, first, r, vcyc;
        logic [3:0] er;
        logic       ef;

        rst_n   = 1'b0;
        roll_in = 1'b0;
        rnd_in  = 8'd0;
        sides   = 4'd0;
        repeat (3) step();
        check("rst_result", 32'(result), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fallback", 32'(fallback), 32'd0);
        check("rst_count", 32'(roll_count), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();

        // Scripted draws 9, F, 3 on a d6 -> third draw accepted as 4.
        script.delete();
        script.push_back({4'($urandom), 4'h9});
        script.push_back({4'($urandom), 4'hF});
        script.push_back({4'($urandom), 4'h3});
        do_roll("d6_script", 4'd6, 20, 1'b0, 1'b1);
        check("d6_script_val", 32'(result), 32'd4);
        check("d6_script_fb", 32'(fallback), 32'd0);

        // Constant F on a d3: all draws rejected; released while still sampling.
        script.delete();
        for (int i = 0; i < 16; i++) script.push_back({4'($urandom), 4'hF});
        do_roll("d3_fallback", 4'd3, 8, 1'b0, 1'b1);
        check("d3_fallback_val", 32'(result), 32'd1);
        check("d3_fallback_fb", 32'(fallback), 32'd1);

        do_roll("sides0", 4'd0, 12, 1'b0, 1'b0);
        do_roll("sides1", 4'd1, 12, 1'b1, 1'b0);

        // Button glitch shorter than the debounce window.
        vc0 = valid_count;
        p = cyc + 1;
        roll_level = 1'b1;
        repeat (3) step();
        roll_level = 1'b0;
        repeat (10) begin
            step();
            if (cyc == p + 3) check("glitch_busy_deb", 32'(busy), 32'd1);
        end
        check("glitch_nvalid", 32'(valid_count - vc0), 32'd0);
        check("glitch_busy_end", 32'(busy), 32'd0);

        for (int i = 0; i < 20; i++)
            do_roll("rand", 4'($urandom_range(0, 15)), $urandom_range(7, 20), 1'b1, 1'b0);

        // Reset pulse while sampling (draws forced to reject so SAMPLE persists).
        script.delete();
        for (int i = 0; i < 16; i++) script.push_back(8'hFF);
        sides_lvl = 4'd5;
        p = cyc + 1;
        first = p + 2 + DEB;
        script_base = first;
        roll_level = 1'b1;
        while (cyc < first + 2) step();
        check("mid_busy", 32'(busy), 32'd1);
        vc0 = valid_count;
        rst_n = 1'b0;
        #1;
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_fallback", 32'(fallback), 32'd0);
        check("mid_rst_count", 32'(roll_count), 32'd0);
        roll_level = 1'b0;
        step();
        rst_n = 1'b1;
        exp_rolls = 0;
        script_base = -1000;
        repeat (12) step();
        check("mid_rst_nvalid", 32'(valid_count - vc0), 32'd0);
        check("mid_rst_busy_end", 32'(busy), 32'd0);

        // Button held through reset: roll must restart via sync and debounce only.
        sides_lvl = 4'd8;
        roll_level = 1'b1;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp_rolls = 0;
        r = cyc;
        vc0 = valid_count;
        step();
        check("held_busy_sync1", 32'(busy), 32'd0);
        step();
        check("held_busy_sync2", 32'(busy), 32'd0);
        step();
        check("held_busy_deb", 32'(busy), 32'd1);
        repeat (15) step();
        roll_level = 1'b0;
        repeat (12) step();
        model(r + 2 + DEB, 4'd8, er, ef, vcyc);
        exp_rolls++;
        check("held_npulse", 32'(valid_count - vc0), 32'd1);
        check("held_vcyc", 32'(last_valid_cyc), 32'(vcyc));
        check("held_out", 32'({fallback, result}), 32'({ef, er}));

        // 257 press/release cycles from a clean reset.
        pulse_reset();
        repeat (3) step();
        for (int i = 0; i < 257; i++)
            do_roll("loop", 4'($urandom_range(0, 15)), $urandom_range(7, 14), 1'b1, 1'b0);
`ifdef PRNG_DICE_ROLL_COUNT_EN
        check("count_257", 32'(roll_count), 32'd1);
`else
        check("count_257", 32'(roll_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
